// File: rtl/hazard_pkg.sv
// Shared constants for the scoreboard hazard unit.
//   COND_BEZ / COND_BNE : Type_Of_Branch codes that mark an ID-stage branch
//   BRANCH_W            : width of Type_Of_Branch
//   DEFAULT_LAT_W       : default pending-counter width
//   DEFAULT_MAX_LATENCY : default longest result latency in cycles
package hazard_pkg;

    localparam int unsigned BRANCH_W            = 2;
    localparam int unsigned DEFAULT_LAT_W       = 2;
    localparam int unsigned DEFAULT_MAX_LATENCY = 3;

    localparam logic [BRANCH_W-1:0] COND_BEZ = 2'b01;
    localparam logic [BRANCH_W-1:0] COND_BNE = 2'b10;

endpackage : hazard_pkg

// File: rtl/hazard_pend_counter.sv
// One scoreboard entry: countdown of cycles until a register's pending write lands.
//   Clock, Reset (async, active-high)
//   load_i     : accepted issue writes this register; overrides the decrement
//   latency_i  : requested latency (0 -> 1, above MAX_LATENCY -> MAX_LATENCY)
//   pend_o     : current countdown; nonzero means a write is pending
module hazard_pend_counter
    import hazard_pkg::*;
#(
    parameter int unsigned LAT_W       = DEFAULT_LAT_W,
    parameter int unsigned MAX_LATENCY = DEFAULT_MAX_LATENCY
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load_i,
    input  logic [LAT_W-1:0] latency_i,
    output logic [LAT_W-1:0] pend_o
);

    logic [LAT_W-1:0] pend_q;
    logic [LAT_W-1:0] pend_d;
    logic [LAT_W-1:0] eff_latency;

    // Clamp the requested latency into 1..MAX_LATENCY
    always_comb begin
        eff_latency = latency_i;
        if (latency_i == '0) begin
            eff_latency = LAT_W'(1);
        end else if (latency_i > LAT_W'(MAX_LATENCY)) begin
            eff_latency = LAT_W'(MAX_LATENCY);
        end
    end

    // Load wins over decrement; zero holds
    always_comb begin
        pend_d = pend_q;
        if (load_i) begin
            pend_d = eff_latency;
        end else if (pend_q != '0) begin
            pend_d = pend_q - LAT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule : hazard_pend_counter

// File: rtl/scoreboard_hazard_unit.sv
// Register scoreboard with per-register write countdowns and ID-stage hazard detection.
//   Clock, Reset (async, active-high)
//   Source_Register_1/2, Is_Immediate, Store_or_BNE, Type_Of_Branch : ID operands
//   Enabled_Data_Forwarding : forwarding network active
//   Issue_Valid/Write_En/Dest/Latency, Flush : issue interface
//   Hazard_Detected : combinational stall request
//   Busy_Mask       : per-register pending-write flags
//   Stall_Count     : saturating stall-cycle counter, only with HAZARD_STALL_COUNTER_EN
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = 4,
    parameter int unsigned MAX_LATENCY  = DEFAULT_MAX_LATENCY,
    parameter int unsigned LAT_W        = DEFAULT_LAT_W
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [REG_ADDR_LEN-1:0]   Source_Register_1,
    input  logic [REG_ADDR_LEN-1:0]   Source_Register_2,
    input  logic                      Is_Immediate,
    input  logic                      Store_or_BNE,
    input  logic [BRANCH_W-1:0]       Type_Of_Branch,
    input  logic                      Enabled_Data_Forwarding,
    input  logic                      Issue_Valid,
    input  logic                      Issue_Write_En,
    input  logic [REG_ADDR_LEN-1:0]   Issue_Dest,
    input  logic [LAT_W-1:0]          Issue_Latency,
    input  logic                      Flush,
    output logic                      Hazard_Detected,
    output logic [2**REG_ADDR_LEN-1:0] Busy_Mask
`ifdef HAZARD_STALL_COUNTER_EN
    ,
    output logic [31:0]               Stall_Count
`endif
);

    localparam int unsigned NUM_REGS = 2**REG_ADDR_LEN;

    logic [NUM_REGS-1:0][LAT_W-1:0] pend_cnt;
    logic                           issue_accept;
    logic                           is_branch;
    logic                           src2_valid;
    logic [LAT_W-1:0]               src1_pend;
    logic [LAT_W-1:0]               src2_pend;
    logic                           src1_conflict;
    logic                           src2_conflict;

    assign issue_accept = Issue_Valid & ~Hazard_Detected & ~Flush;

    // One countdown per architectural register
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        hazard_pend_counter #(
            .LAT_W       (LAT_W),
            .MAX_LATENCY (MAX_LATENCY)
        ) u_pend (
            .Clock     (Clock),
            .Reset     (Reset),
            .load_i    (issue_accept & Issue_Write_En & (Issue_Dest == REG_ADDR_LEN'(r))),
            .latency_i (Issue_Latency),
            .pend_o    (pend_cnt[r])
        );
        assign Busy_Mask[r] = (pend_cnt[r] != '0);
    end

    // Forwarding covers a result landing next cycle, except for branches
    // which resolve in ID and cannot take a forwarded operand.
    always_comb begin
        is_branch     = (Type_Of_Branch == COND_BEZ) || (Type_Of_Branch == COND_BNE);
        src2_valid    = ~Is_Immediate | Store_or_BNE;
        src1_pend     = pend_cnt[Source_Register_1];
        src2_pend     = pend_cnt[Source_Register_2];
        src1_conflict = 1'b0;
        src2_conflict = 1'b0;
        if (Enabled_Data_Forwarding) begin
            src1_conflict = (src1_pend > LAT_W'(1)) || (is_branch && (src1_pend != '0));
            src2_conflict = src2_valid &&
                            ((src2_pend > LAT_W'(1)) || (is_branch && (src2_pend != '0)));
        end else begin
            src1_conflict = (src1_pend != '0);
            src2_conflict = src2_valid && (src2_pend != '0);
        end
    end

    assign Hazard_Detected = Issue_Valid & ~Flush & (src1_conflict | src2_conflict);

`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_count_d = stall_count_q;
        if (Hazard_Detected && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign Stall_Count = stall_count_q;
`endif

endmodule : scoreboard_hazard_unit

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed self-checking bench for scoreboard_hazard_unit.
// Instance a uses defaults (MAX_LATENCY 3); instance b shares all inputs
// with MAX_LATENCY 2 to exercise latency clamping.
module tb_scoreboard_hazard_unit;
    import hazard_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Source_Register_1;
    logic [3:0]  Source_Register_2;
    logic        Is_Immediate;
    logic        Store_or_BNE;
    logic [1:0]  Type_Of_Branch;
    logic        Enabled_Data_Forwarding;
    logic        Issue_Valid;
    logic        Issue_Write_En;
    logic [3:0]  Issue_Dest;
    logic [1:0]  Issue_Latency;
    logic        Flush;
    logic        hz_a;
    logic        hz_b;
    logic [15:0] busy_a;
    logic [15:0] busy_b;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_a;
    logic [31:0] stall_b;
`endif

    int vectors     = 0;
    int miscompares = 0;

    scoreboard_hazard_unit #(.REG_ADDR_LEN(4), .MAX_LATENCY(3), .LAT_W(2)) dut_a (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .Source_Register_1       (Source_Register_1),
        .Source_Register_2       (Source_Register_2),
        .Is_Immediate            (Is_Immediate),
        .Store_or_BNE            (Store_or_BNE),
        .Type_Of_Branch          (Type_Of_Branch),
        .Enabled_Data_Forwarding (Enabled_Data_Forwarding),
        .Issue_Valid             (Issue_Valid),
        .Issue_Write_En          (Issue_Write_En),
        .Issue_Dest              (Issue_Dest),
        .Issue_Latency           (Issue_Latency),
        .Flush                   (Flush),
        .Hazard_Detected         (hz_a),
        .Busy_Mask               (busy_a)
`ifdef HAZARD_STALL_COUNTER_EN
        ,
        .Stall_Count             (stall_a)
`endif
    );

    scoreboard_hazard_unit #(.REG_ADDR_LEN(4), .MAX_LATENCY(2), .LAT_W(2)) dut_b (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .Source_Register_1       (Source_Register_1),
        .Source_Register_2       (Source_Register_2),
        .Is_Immediate            (Is_Immediate),
        .Store_or_BNE            (Store_or_BNE),
        .Type_Of_Branch          (Type_Of_Branch),
        .Enabled_Data_Forwarding (Enabled_Data_Forwarding),
        .Issue_Valid             (Issue_Valid),
        .Issue_Write_En          (Issue_Write_En),
        .Issue_Dest              (Issue_Dest),
        .Issue_Latency           (Issue_Latency),
        .Flush                   (Flush),
        .Hazard_Detected         (hz_b),
        .Busy_Mask               (busy_b)
`ifdef HAZARD_STALL_COUNTER_EN
        ,
        .Stall_Count             (stall_b)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Issue_Valid = 1'b0; Issue_Write_En = 1'b0; Issue_Dest = 4'd0; Issue_Latency = 2'd1;
        Source_Register_1 = 4'd0; Source_Register_2 = 4'd0;
        Is_Immediate = 1'b1; Store_or_BNE = 1'b0; Type_Of_Branch = 2'b00;
        Enabled_Data_Forwarding = 1'b1; Flush = 1'b0;
    endtask

    task automatic issue_wr(input logic [3:0] dest, input logic [1:0] lat);
        idle();
        Issue_Valid = 1'b1; Issue_Write_En = 1'b1; Issue_Dest = dest; Issue_Latency = lat;
    endtask

    task automatic consume(input logic [3:0] s1, input logic [3:0] s2, input logic imm,
                           input logic sbne, input logic [1:0] br, input logic fwd);
        idle();
        Issue_Valid = 1'b1;
        Source_Register_1 = s1; Source_Register_2 = s2;
        Is_Immediate = imm; Store_or_BNE = sbne; Type_Of_Branch = br;
        Enabled_Data_Forwarding = fwd;
    endtask

    // Inputs change at the falling edge; checks sample 1 time unit later.
    task automatic cyc();
        @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        cyc();
        consume(4'd3, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0); #1;
        chk("reset_busy", 32'(busy_a), 32'h0);
        chk("reset_hz", 32'(hz_a), 32'h0);
        cyc(); Reset = 1'b0; idle(); #1;

        // ALU result, latency 1, forwarding on
        cyc(); issue_wr(4'd3, 2'd1); #1;
        chk("fwd_issue_hz", 32'(hz_a), 32'h0);
        cyc(); consume(4'd3, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1); #1;
        chk("fwd_alu_hz", 32'(hz_a), 32'h0);
        chk("fwd_alu_busy", 32'(busy_a), 32'h0008);
        cyc(); idle(); #1;
        chk("alu_done_busy", 32'(busy_a), 32'h0);

        // Same with forwarding off: one stall cycle
        cyc(); issue_wr(4'd3, 2'd1); #1;
        cyc(); consume(4'd3, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0); #1;
        chk("nofwd_stall_hz", 32'(hz_a), 32'h1);
        cyc(); consume(4'd3, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0); #1;
        chk("nofwd_release_hz", 32'(hz_a), 32'h0);

        // Load latency 3, consumer on src2 with forwarding: two stalls
        cyc(); issue_wr(4'd5, 2'd3); #1;
        cyc(); consume(4'd0, 4'd5, 1'b0, 1'b0, 2'b00, 1'b1); #1;
        chk("load_stall1_hz", 32'(hz_a), 32'h1);
        chk("load_busy", 32'(busy_a), 32'h0020);
        cyc(); consume(4'd0, 4'd5, 1'b0, 1'b0, 2'b00, 1'b1); #1;
        chk("load_stall2_hz", 32'(hz_a), 32'h1);
        cyc(); consume(4'd0, 4'd5, 1'b0, 1'b0, 2'b00, 1'b1); #1;
        chk("load_issue_hz", 32'(hz_a), 32'h0);

        // BNE on a latency-1 result: branches cannot forward
        cyc(); issue_wr(4'd2, 2'd1); #1;
        cyc(); consume(4'd2, 4'd0, 1'b1, 1'b1, COND_BNE, 1'b1); #1;
        chk("bne_stall_hz", 32'(hz_a), 32'h1);
        cyc(); consume(4'd2, 4'd0, 1'b1, 1'b1, COND_BNE, 1'b1); #1;
        chk("bne_issue_hz", 32'(hz_a), 32'h0);

        // src2 qualification by Is_Immediate / Store_or_BNE
        cyc(); issue_wr(4'd7, 2'd3); #1;
        cyc(); consume(4'd0, 4'd7, 1'b1, 1'b0, 2'b00, 1'b1); #1;
        chk("imm_src2_ignored_hz", 32'(hz_a), 32'h0);
        cyc(); consume(4'd0, 4'd7, 1'b1, 1'b1, 2'b00, 1'b1); #1;
        chk("store_src2_hz", 32'(hz_a), 32'h1);
        cyc(); idle(); #1;

        // Latency 0 behaves as 1
        cyc(); issue_wr(4'd4, 2'd0); #1;
        cyc(); idle(); #1;
        chk("lat0_busy", 32'(busy_a), 32'h0010);
        // Re-issue to a busy register overrides its count
        cyc(); issue_wr(4'd6, 2'd3); #1;
        chk("lat0_done_busy", 32'(busy_a), 32'h0);
        cyc(); issue_wr(4'd6, 2'd1); #1;
        chk("reissue_busy", 32'(busy_a), 32'h0040);
        cyc(); idle(); #1;
        chk("reissue_busy_last", 32'(busy_a), 32'h0040);
        cyc(); idle(); #1;
        chk("reissue_override_busy", 32'(busy_a), 32'h0);

`ifdef HAZARD_STALL_COUNTER_EN
        chk("stall_count_a", stall_a, 32'd5);
`endif

        // Flush suppresses hazard and the issue; clamp visible on instance b
        cyc(); issue_wr(4'd9, 2'd3); #1;
        cyc(); consume(4'd9, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        Flush = 1'b1; Issue_Write_En = 1'b1; Issue_Dest = 4'd10; Issue_Latency = 2'd3; #1;
        chk("flush_hz", 32'(hz_a), 32'h0);
        chk("flush_busy", 32'(busy_a), 32'h0200);
        cyc(); idle(); #1;
        chk("flush_no_load_busy", 32'(busy_a), 32'h0200);
        chk("clamp_b_busy", 32'(busy_b), 32'h0200);
        cyc(); consume(4'd9, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0); #1;
        chk("clamp_b_done_busy", 32'(busy_b), 32'h0);
        chk("pending_a_busy", 32'(busy_a), 32'h0200);
        chk("pending_a_hz", 32'(hz_a), 32'h1);

        // Asynchronous reset mid-pending clears immediately
        #1 Reset = 1'b1; #1;
        chk("async_reset_busy", 32'(busy_a), 32'h0);
        chk("async_reset_hz", 32'(hz_a), 32'h0);
`ifdef HAZARD_STALL_COUNTER_EN
        chk("async_reset_stall", stall_a, 32'h0);
`endif
        cyc(); Reset = 1'b0; consume(4'd9, 4'd9, 1'b0, 1'b0, 2'b00, 1'b0); #1;
        chk("post_reset_hz", 32'(hz_a), 32'h0);
        chk("post_reset_busy", 32'(busy_a), 32'h0);

        cyc(); idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_scoreboard_hazard_unit

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_LEN, default 4, register address width (NUM_REGS = 2**REG_ADDR_LEN).
REQ-002 SHALL have parameter MAX_LATENCY, default 3, longest result latency in cycles (legal 1..15).
REQ-003 SHALL have parameter LAT_W, default 2, counter width, at least clog2(MAX_LATENCY+1).
REQ-004 Clock  in  1  single system clock; all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Source_Register_1, Source_Register_2  in  REG_ADDR_LEN each  ID-stage source addresses.
REQ-007 Is_Immediate, Store_or_BNE  in  1 each  operand-2 qualifiers; src2 is valid when ~Is_Immediate or Store_or_BNE.
REQ-008 Type_Of_Branch  in  2  ID-stage branch code; the instruction is a branch when the code equals COND_BEZ or COND_BNE.
REQ-009 Enabled_Data_Forwarding  in  1  forwarding network active.
REQ-010 Issue_Valid  in  1  ID instruction attempts issue this cycle.
REQ-011 Issue_Write_En  in  1  issuing instruction writes Issue_Dest.
REQ-012 Issue_Dest  in  REG_ADDR_LEN  destination register.
REQ-013 Issue_Latency  in  LAT_W  cycles until write-back (1 = plain ALU).
REQ-014 Flush  in  1  squashes the ID instruction this cycle.
REQ-015 Hazard_Detected  out  1  stall ID/IF this cycle (combinational).
REQ-016 Busy_Mask  out  NUM_REGS  bit r set when register r has a pending write.
REQ-017 Stall_Count  out  32  stall-cycle counter (present only under HAZARD_STALL_COUNTER_EN).

Function
REQ-018 SHALL hold one LAT_W-bit countdown Pend[r] per register; Busy_Mask[r] = (Pend[r] != 0).
REQ-019 Each cycle every nonzero Pend[r] SHALL decrement by 1; zero entries SHALL hold.
REQ-020 An issue SHALL be accepted when Issue_Valid & ~Hazard_Detected & ~Flush.
REQ-021 On an accepted issue with Issue_Write_En, Pend[Issue_Dest] SHALL load the effective latency next edge, overriding the decrement for that entry in the same cycle.
REQ-022 Effective latency: an Issue_Latency of 0 SHALL be treated as 1; a value above MAX_LATENCY SHALL be clamped to MAX_LATENCY.
REQ-023 A source SHALL conflict without forwarding when it is valid and Pend[src] != 0; src1 is always valid.
REQ-024 A source SHALL conflict with forwarding when it is valid and either Pend[src] > 1, or Pend[src] != 0 and the instruction is a branch.
REQ-025 Hazard_Detected SHALL be Issue_Valid & ~Flush & (conflict on src1 | conflict on src2).
REQ-026 Identical src1/src2/dest addresses SHALL need no special handling; the lookup is per address.
REQ-027 Flush SHALL NOT alter Pend; already-issued writes complete.
REQ-028 A stalled instruction SHALL be re-evaluated every cycle with no added latency; the stall releases in the cycle its condition clears.

Reset
REQ-029 Reset asserted SHALL immediately clear all Pend (Busy_Mask = 0, Hazard_Detected = 0 unless stimulus conflicts, none possible) and Stall_Count = 0.
REQ-030 Reset mid-stall SHALL discard all pending writes; the first post-reset cycle sees no hazards.

Configuration
REQ-031 With HAZARD_STALL_COUNTER_EN defined, Stall_Count SHALL increment by 1 on each cycle Hazard_Detected = 1 and saturate at 32'hFFFF_FFFF.
REQ-032 Without HAZARD_STALL_COUNTER_EN, the Stall_Count port and its logic SHALL not exist.

Structure
REQ-033 Package hazard_pkg SHALL hold COND_BEZ, COND_BNE, the Type_Of_Branch width and the default LAT_W/MAX_LATENCY constants.
REQ-034 Sub-module hazard_pend_counter (one countdown entry with load, clamp and decrement) SHALL be instantiated NUM_REGS times via generate.

Verification
REQ-035 Issue R3 with latency 1, then ALU reading R3 next cycle with forwarding on -> Hazard_Detected = 0; with forwarding off -> 1 for one cycle.
REQ-036 Load R5 with latency 3, then consumer of R5 with forwarding on -> stall 2 cycles (Pend 3->2->1), issues when Pend = 1.
REQ-037 BNE reading R2 right after an R2 write with latency 1, forwarding on -> 1 stall cycle, then issue.
REQ-038 Is_Immediate = 1, Store_or_BNE = 0, src2 = busy R7 -> no hazard; with Store_or_BNE = 1 -> hazard.
REQ-039 Issue_Latency = 0 -> Busy_Mask bit set for 1 cycle; Issue_Latency = 3 with MAX_LATENCY = 2 -> Pend = 2; re-issue to a busy reg overrides its count.
REQ-040 Reset during a 3-cycle pending load -> Busy_Mask = 0 immediately, Stall_Count = 0; Flush with a conflicting source -> Hazard_Detected = 0, Pend unchanged.
